// File: rtl/irom_loader_pkg.sv
// Shared definitions for the run-time IROM loader: FSM encoding and frame layout.
package irom_loader_pkg;
   localparam int WORD_W          = 32;
   localparam int BYTES_PER_WORD  = WORD_W / 8;
   localparam int FRAME_HDR_BYTES = 2;
   localparam int POS_LEN_LO      = 0;
   localparam int POS_LEN_HI      = 1;
   localparam int POS_DATA        = FRAME_HDR_BYTES;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CSUM   = 3'd5,
      S_ERR    = 3'd6
   } state_t;
endpackage

// File: rtl/irom_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; word is valid with word_full.
module irom_word_packer
   import irom_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [7:0]        byte_data,
   output logic              word_full,
   output logic [WORD_W-1:0] word
);
   logic [1:0]        cnt;
   logic [WORD_W-9:0] sreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (byte_en) begin
         cnt <= cnt + 2'd1;
      end
   end

   // Bytes enter at the top and drift down, so the oldest byte ends in [7:0].
   always_ff @(posedge clk) begin
      if (byte_en) sreg <= {byte_data, sreg[WORD_W-9:8]};
   end

   assign word_full = byte_en && (cnt == 2'd3);
   assign word      = {byte_data, sreg};
endmodule

// File: rtl/irom_loader.sv
// Receives a framed program image over a byte link and writes it into the IROM,
// holding the CPU in reset until a load completes with a good checksum.
module irom_loader
   import irom_loader_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              irom_we,
   output logic [ADDR_W-1:0] irom_addr,
   output logic [WORD_W-1:0] irom_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);
   state_t            state, next;
   logic [15:0]       len;
   logic [7:0]        csum;
   logic              xfer, go, word_full, oversize, last_word, csum_ok;
   logic [15:0]       n_val;
   logic [WORD_W-1:0] word;

   assign xfer      = byte_valid && byte_ready;
   assign go        = start && (state == S_IDLE || state == S_ERR);
   assign n_val     = {byte_data, len[7:0]};
   assign oversize  = {16'b0, n_val} > 32'(DEPTH);
   assign last_word = (32'(irom_addr) + 32'd1) == {16'b0, len};
   assign csum_ok   = byte_data == csum;

   irom_word_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (go),
      .byte_en   (xfer && state == S_DATA),
      .byte_data (byte_data),
      .word_full (word_full),
      .word      (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next;
   end

   always_comb begin
      next       = state;
      byte_ready = 1'b0;
      irom_we    = 1'b0;
      case (state)
         S_IDLE, S_ERR: if (start) next = S_LEN_LO;
         S_LEN_LO: begin
            byte_ready = 1'b1;
            if (xfer) next = S_LEN_HI;
         end
         S_LEN_HI: begin
            byte_ready = 1'b1;
            if (xfer) begin
               if (n_val == 16'd0) next = S_CSUM;
               else if (oversize)  next = S_ERR;
               else                next = S_DATA;
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            if (word_full) next = S_WRITE;
         end
         S_WRITE: begin
            irom_we = 1'b1;
            next    = last_word ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            byte_ready = 1'b1;
            if (xfer) next = csum_ok ? S_IDLE : S_ERR;
         end
         default: next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irom_addr  <= '0;
         irom_wdata <= '0;
         cpu_hold   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (go) begin
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            irom_addr <= '0;
         end
         if (word_full)         irom_wdata <= word;
         if (state == S_WRITE)  irom_addr  <= irom_addr + 1'b1;
         if (state == S_LEN_HI && xfer && n_val != 16'd0 && oversize) err <= 1'b1;
         // A bad checksum leaves cpu_hold high so a corrupt image never runs.
         if (state == S_CSUM && xfer) begin
            if (csum_ok) begin
               done     <= 1'b1;
               cpu_hold <= 1'b0;
            end else begin
               err      <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (go) csum <= 8'd0;
      else if (xfer && (state == S_LEN_LO || state == S_LEN_HI || state == S_DATA))
         csum <= csum + byte_data;
      if (xfer && state == S_LEN_LO) len[7:0]  <= byte_data;
      if (xfer && state == S_LEN_HI) len[15:8] <= byte_data;
   end
endmodule

// File: tb/tb_irom_loader.sv
// Randomised scoreboard bench for irom_loader: frames are built from word lists,
// expected IROM writes are queued and checked by an independent monitor.
module tb_irom_loader;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              irom_we;
   logic [ADDR_W-1:0] irom_addr;
   logic [31:0]       irom_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   irom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .irom_we    (irom_we),
      .irom_addr  (irom_addr),
      .irom_wdata (irom_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] words_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every IROM write must match the oldest expected write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && irom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d data 0x%h, required no write",
                        irom_addr, irom_wdata);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(irom_addr), 32'(e.addr));
               check("write_data", irom_wdata, e.data);
               check("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
            end
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_hold", {31'b0, cpu_hold}, 32'd1);
      check("start_done", {31'b0, done}, 32'd0);
      check("start_err", {31'b0, err}, 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int t;
      byte_valid = 1'b0;
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         t++;
         if (t > 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: byte 0x%h got byte_ready=0, required 1", b);
            byte_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   // Sends a frame built from words_q; csum_delta != 0 corrupts the checksum.
   task automatic run_frame(input int gap_pct, input int csum_delta, input bit do_start);
      logic [7:0] fb[$];
      int         n, sum;
      logic [7:0] ck;
      n   = words_q.size();
      fb  = {};
      fb.push_back(8'(n % 256));
      fb.push_back(8'(n / 256));
      foreach (words_q[i])
         for (int k = 0; k < 4; k++) fb.push_back(8'((words_q[i] >> (8 * k)) % 256));
      sum = 0;
      foreach (fb[i]) sum = sum + int'(fb[i]);
      ck = 8'((sum + csum_delta) % 256);
      if (do_start) pulse_start();
      foreach (fb[j]) begin
         if (j >= 2 && (j - 2) % 4 == 3) begin
            wr_t e;
            e.addr = (j - 2) / 4;
            e.data = words_q[(j - 2) / 4];
            exp_q.push_back(e);
         end
         send_byte(fb[j], gap_pct);
      end
      send_byte(ck, gap_pct);
      check("frame_done", {31'b0, done}, (csum_delta % 256 == 0) ? 32'd1 : 32'd0);
      check("frame_err", {31'b0, err}, (csum_delta % 256 == 0) ? 32'd0 : 32'd1);
      check("frame_hold", {31'b0, cpu_hold}, (csum_delta % 256 == 0) ? 32'd0 : 32'd1);
   endtask

   task automatic check_reset_vals();
      check("rst_ready", {31'b0, byte_ready}, 32'd0);
      check("rst_we", {31'b0, irom_we}, 32'd0);
      check("rst_addr", 32'(irom_addr), 32'd0);
      check("rst_wdata", irom_wdata, 32'd0);
      check("rst_hold", {31'b0, cpu_hold}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Two-word load; this frame sums to 0xE2.
      words_q = '{32'h00100513, 32'h00200593};
      run_frame(0, 0, 1'b1);

      words_q = {};
      run_frame(0, 0, 1'b1);

      // Same frame with checksum 0xE6.
      words_q = '{32'h00100513, 32'h00200593};
      run_frame(0, 4, 1'b1);
      pulse_start();
      words_q = {};
      run_frame(0, 0, 1'b0);

      // Oversize: LEN = DEPTH + 1.
      pulse_start();
      send_byte(8'((DEPTH + 1) % 256), 0);
      send_byte(8'((DEPTH + 1) / 256), 0);
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("oversize_ready", {31'b0, byte_ready}, 32'd0);
      end
      check("oversize_err", {31'b0, err}, 32'd1);
      check("oversize_hold", {31'b0, cpu_hold}, 32'd1);
      check("oversize_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      byte_valid = 1'b0;

      // Gaps and backpressure, then random frames.
      words_q = '{32'h00100513, 32'h00200593};
      run_frame(60, 0, 1'b1);
      for (int f = 0; f < 8; f++) begin
         words_q = {};
         for (int w = 0; w < int'($urandom_range(1, 6)); w++) words_q.push_back($urandom);
         run_frame(int'($urandom_range(0, 70)),
                   ($urandom_range(99) < 30) ? int'($urandom_range(1, 255)) : 0, 1'b1);
      end

      // Reset after six data bytes of the two-word frame.
      words_q = '{32'h00100513, 32'h00200593};
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin
            wr_t e;
            e.addr = 0;
            e.data = words_q[0];
            exp_q.push_back(e);
         end
         send_byte(8'((words_q[k / 4] >> (8 * (k % 4))) % 256), 0);
      end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(30, 0, 1'b1);

      repeat (4) @(posedge clk);
      #1;
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
